// File: rtl/port_bind_arbiter_if.sv
// rtl/port_bind_arbiter_if.sv - requester/arbiter bundle for the listen-port bind table
interface port_bind_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NENT  = 8,
  parameter int PORTW = 16
);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(NENT + 1);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*PORTW-1:0] req_port;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [1:0]            rsp_code;
  logic [CNTW-1:0]       bound_count;

  modport master (
    output req_valid, req_op, req_port,
    input  req_ready, rsp_valid, rsp_id, rsp_code, bound_count
  );

  modport slave (
    input  req_valid, req_op, req_port,
    output req_ready, rsp_valid, rsp_id, rsp_code, bound_count
  );
endinterface

// File: rtl/port_bind_arbiter.sv
// rtl/port_bind_arbiter.sv - round-robin arbiter serialising bind/release against a shared listen-port table
module port_bind_arbiter #(
  parameter int NREQ     = 4,
  parameter int NENT     = 8,
  parameter int PORTW    = 16,
  parameter int CFG_PORT = 22202
) (
  input  logic                clk,
  input  logic                rst,
  port_bind_arbiter_if.slave  bus
);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IXW  = $clog2(NENT);
  localparam int CNTW = $clog2(NENT + 1);

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_TAKEN = 2'b01;
  localparam logic [1:0] CODE_FULL  = 2'b10;
  localparam logic [1:0] CODE_NF    = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NENT-1:0]  valid_q;
  logic [PORTW-1:0] port_q [NENT];

  logic [IDW-1:0]   rr_ptr;
  logic             lat_op;
  logic [PORTW-1:0] lat_port;
  logic [IDW-1:0]   lat_id;
  logic [IXW-1:0]   idx;
  logic             match_found, free_found;
  logic [IXW-1:0]   match_idx, free_idx;
  logic [1:0]       rsp_code_q;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  req_ready_c;
  logic [1:0]       commit_code;
  logic             do_bind, do_clear;
  logic [CNTW-1:0]  cnt;

  // Walk downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int j;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready_c[gnt_id] = 1'b1;
          state_nxt           = SCAN;
        end
      end
      SCAN:    if (idx == IXW'(NENT - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Entry 0 holds the config port: it matches on bind/release but can never be cleared.
  always_comb begin
    commit_code = CODE_OK;
    do_bind     = 1'b0;
    do_clear    = 1'b0;
    if (lat_port == '0) begin
      commit_code = CODE_NF;
    end else if (!lat_op) begin
      if (match_found)      commit_code = CODE_TAKEN;
      else if (!free_found) commit_code = CODE_FULL;
      else                  do_bind = 1'b1;
    end else begin
      if (!match_found)            commit_code = CODE_NF;
      else if (match_idx == '0)    commit_code = CODE_TAKEN;
      else                         do_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        valid_q[i] <= (i == 0);
        port_q[i]  <= (i == 0) ? PORTW'(CFG_PORT) : '0;
      end
      rr_ptr      <= '0;
      lat_op      <= 1'b0;
      lat_port    <= '0;
      lat_id      <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rsp_code_q  <= CODE_OK;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            lat_op      <= bus.req_op[gnt_id];
            lat_port    <= bus.req_port[int'(gnt_id)*PORTW +: PORTW];
            lat_id      <= gnt_id;
            rr_ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
          end
        end
        SCAN: begin
          if (valid_q[idx] && port_q[idx] == lat_port) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!valid_q[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + 1'b1;
        end
        COMMIT: begin
          rsp_code_q <= commit_code;
          if (do_bind) begin
            valid_q[free_idx] <= 1'b1;
            port_q[free_idx]  <= lat_port;
          end
          if (do_clear) valid_q[match_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NENT; i++) cnt = cnt + CNTW'(valid_q[i]);
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = lat_id;
  assign bus.rsp_code    = rsp_code_q;
  assign bus.bound_count = cnt;
endmodule

// File: tb/tb_port_bind_arbiter.sv
// tb/tb_port_bind_arbiter.sv - directed bench for port_bind_arbiter
module tb_port_bind_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  port_bind_arbiter_if #(.NREQ(4), .NENT(8), .PORTW(16)) bus();

  port_bind_arbiter #(.NREQ(4), .NENT(8), .PORTW(16), .CFG_PORT(22202)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_port  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request and returns what came back; t_acc/t_rsp stay -1 on timeout.
  task automatic do_req(input int id, input bit op, input int port,
                        output logic [1:0] code, output int rid,
                        output int t_acc, output int t_rsp);
    code = 2'bxx; rid = -1; t_acc = -1; t_rsp = -1;
    @(negedge clk);
    bus.req_valid[id] = 1'b1;
    bus.req_op[id]    = op;
    bus.req_port[id*16 +: 16] = 16'(port);
    for (int n = 0; n < 40 && t_acc < 0; n++) begin
      #1;
      if (bus.req_ready[id]) t_acc = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    if (t_acc < 0) return;
    for (int n = 0; n < 40 && t_rsp < 0; n++) begin
      if (bus.rsp_valid) begin
        t_rsp = cyc; code = bus.rsp_code; rid = int'(bus.rsp_id);
      end else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
    n_vec++; if (bus.rsp_code !== 2'b00) begin n_err++; $display("FAIL reset_rsp_code got %b want 00", bus.rsp_code); end
    n_vec++; if (bus.bound_count !== 4'd1) begin n_err++; $display("FAIL reset_bound_count got %0d want 1", bus.bound_count); end
  endtask

  task automatic test_bind_basic();
    logic [1:0] code; int rid, ta, tr;
    apply_reset();
    do_req(1, 1'b0, 80, code, rid, ta, tr);
    n_vec++; if (ta < 0 || tr - ta !== 10) begin n_err++; $display("FAIL bind80_latency got %0d want 10", tr - ta); end
    n_vec++; if (rid !== 1) begin n_err++; $display("FAIL bind80_id got %0d want 1", rid); end
    n_vec++; if (code !== 2'b00) begin n_err++; $display("FAIL bind80_code got %b want 00", code); end
    n_vec++; if (bus.bound_count !== 4'd2) begin n_err++; $display("FAIL bind80_count got %0d want 2", bus.bound_count); end
  endtask

  task automatic test_contention();
    int t0, t1; bit seen;
    apply_reset();
    @(negedge clk);
    bus.req_valid = 4'b0101;
    bus.req_op    = 4'b0000;
    bus.req_port  = {16'd0, 16'd8080, 16'd0, 16'd8080};
    #1; t0 = cyc;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL contend_first_grant got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++; if (!(bus.rsp_valid === 1'b1 && bus.rsp_id === 2'd0 && bus.rsp_code === 2'b00))
      begin n_err++; $display("FAIL contend_rsp0 got v=%b id=%0d code=%b want v=1 id=0 code=00", bus.rsp_valid, bus.rsp_id, bus.rsp_code); end
    @(negedge clk); #1; t1 = cyc;
    n_vec++; if (bus.req_ready !== 4'b0100 || t1 - t0 !== 11) begin n_err++; $display("FAIL contend_second_grant got %b at +%0d want 0100 at +11", bus.req_ready, t1 - t0); end
    @(negedge clk); bus.req_valid[2] = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++; if (!(bus.rsp_valid === 1'b1 && bus.rsp_id === 2'd2 && bus.rsp_code === 2'b01))
      begin n_err++; $display("FAIL contend_rsp2 got v=%b id=%0d code=%b want v=1 id=2 code=01", bus.rsp_valid, bus.rsp_id, bus.rsp_code); end
    // rr_ptr now 3: requester 3 beats requester 0
    @(negedge clk);
    bus.req_valid = 4'b1001;
    bus.req_port  = {16'd9090, 16'd0, 16'd0, 16'd9091};
    #1;
    n_vec++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL contend_rr_ptr got %b want 1000", bus.req_ready); end
    @(negedge clk); bus.req_valid[3] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (bus.rsp_valid) seen = 1'b1; else @(negedge clk);
    end
    n_vec++; if (!(seen && bus.rsp_id === 2'd3 && bus.rsp_code === 2'b00))
      begin n_err++; $display("FAIL contend_rsp3 got seen=%b id=%0d code=%b want seen=1 id=3 code=00", seen, bus.rsp_id, bus.rsp_code); end
    @(negedge clk); #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL contend_wrap_grant got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_cfg_locked();
    logic [1:0] code; int rid, ta, tr;
    apply_reset();
    do_req(2, 1'b0, 22202, code, rid, ta, tr);
    n_vec++; if (code !== 2'b01) begin n_err++; $display("FAIL cfg_bind got %b want 01", code); end
    do_req(3, 1'b1, 22202, code, rid, ta, tr);
    n_vec++; if (code !== 2'b01) begin n_err++; $display("FAIL cfg_release got %b want 01", code); end
    n_vec++; if (bus.bound_count !== 4'd1) begin n_err++; $display("FAIL cfg_count got %0d want 1", bus.bound_count); end
  endtask

  task automatic test_full_and_refill();
    logic [1:0] code; int rid, ta, tr;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      do_req(i % 4, 1'b0, 1001 + i, code, rid, ta, tr);
      n_vec++; if (code !== 2'b00 || rid !== i % 4) begin n_err++; $display("FAIL fill_%0d got code=%b id=%0d want 00 id=%0d", 1001 + i, code, rid, i % 4); end
    end
    n_vec++; if (bus.bound_count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d want 8", bus.bound_count); end
    do_req(0, 1'b0, 1008, code, rid, ta, tr);
    n_vec++; if (code !== 2'b10) begin n_err++; $display("FAIL full_bind got %b want 10", code); end
    do_req(1, 1'b1, 1003, code, rid, ta, tr);
    n_vec++; if (code !== 2'b00) begin n_err++; $display("FAIL release1003 got %b want 00", code); end
    n_vec++; if (bus.bound_count !== 4'd7) begin n_err++; $display("FAIL release_count got %0d want 7", bus.bound_count); end
    do_req(2, 1'b0, 1008, code, rid, ta, tr);
    n_vec++; if (code !== 2'b00) begin n_err++; $display("FAIL refill_bind got %b want 00", code); end
    n_vec++; if (bus.bound_count !== 4'd8) begin n_err++; $display("FAIL refill_count got %0d want 8", bus.bound_count); end
    do_req(3, 1'b0, 1008, code, rid, ta, tr);
    n_vec++; if (code !== 2'b01) begin n_err++; $display("FAIL rebind1008 got %b want 01", code); end
    do_req(0, 1'b1, 1003, code, rid, ta, tr);
    n_vec++; if (code !== 2'b11) begin n_err++; $display("FAIL rerelease1003 got %b want 11", code); end
  endtask

  task automatic test_invalid();
    logic [1:0] code; int rid, ta, tr;
    apply_reset();
    do_req(0, 1'b1, 5555, code, rid, ta, tr);
    n_vec++; if (code !== 2'b11) begin n_err++; $display("FAIL release_unbound got %b want 11", code); end
    do_req(1, 1'b0, 0, code, rid, ta, tr);
    n_vec++; if (code !== 2'b11) begin n_err++; $display("FAIL bind_port0 got %b want 11", code); end
    n_vec++; if (bus.bound_count !== 4'd1) begin n_err++; $display("FAIL invalid_count got %0d want 1", bus.bound_count); end
    do_req(2, 1'b0, 22203, code, rid, ta, tr);
    n_vec++; if (code !== 2'b00) begin n_err++; $display("FAIL bind_near_cfg got %b want 00", code); end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] code; int rid, ta, tr; bit seen;
    apply_reset();
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_op[0]    = 1'b0;
    bus.req_port[15:0] = 16'd80;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_accept got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_rsp got %b want 0", seen); end
    n_vec++; if (bus.bound_count !== 4'd1) begin n_err++; $display("FAIL midrst_count got %0d want 1", bus.bound_count); end
    do_req(0, 1'b0, 80, code, rid, ta, tr);
    n_vec++; if (code !== 2'b00 || tr - ta !== 10) begin n_err++; $display("FAIL midrst_reissue got code=%b lat=%0d want 00 lat=10", code, tr - ta); end
    n_vec++; if (bus.bound_count !== 4'd2) begin n_err++; $display("FAIL midrst_reissue_count got %0d want 2", bus.bound_count); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_port  = '0;
    test_reset();
    test_bind_basic();
    test_contention();
    test_cfg_locked();
    test_full_and_refill();
    test_invalid();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/port_bind_arbiter.md
# port_bind_arbiter

Shares a fixed-size table of bound TCP listen ports between several requesters (HTTP listener, config interface, protocol modules) and serialises bind/release requests against it. Each request is granted round-robin, scanned against the table, then either committed or rejected with a "port taken", "table full" or "not found" code. The config-interface port is preloaded at reset and locked. It sits between the per-protocol listener front-ends and the socket-table datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NENT, 8, table entries (2..16); entry 0 reserved for config port
- PORTW, 16, port-number width
- CFG_PORT, 22202, port preloaded into entry 0 at reset, locked

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request strobe, held until ready
- req_op  in  NREQ  per-requester op: 0 = bind, 1 = release
- req_port  in  NREQ*PORTW  per-requester port, requester i at bits [i*PORTW +: PORTW]
- req_ready  out  NREQ  one-hot, one-cycle accept pulse
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  clog2(NREQ)  index of the requester being answered
- rsp_code  out  2  00 OK, 01 TAKEN/locked, 10 FULL, 11 NOT_FOUND/invalid
- bound_count  out  clog2(NENT+1)  number of valid entries, including the config entry

## Operation
- Table: NENT entries of {valid, port}. Reset sets entry 0 = {1, CFG_PORT} and entries 1..NENT-1 invalid.
- FSM states are IDLE, SCAN, COMMIT and RESP.
- IDLE:
  - If any req_valid is high, grant the first requester at or after rr_ptr, wrapping.
  - Pulse that requester's req_ready.
  - Latch op, port and id.
  - Set rr_ptr = (grant+1) mod NREQ.
  - Go to SCAN.
  - rr_ptr never changes without a grant.
- SCAN: examine one entry per cycle, idx 0..NENT-1.
  - Record match (valid && port == latched port) and its index.
  - Record the lowest invalid index as the first free entry.
  - Go to COMMIT after idx NENT-1.
- COMMIT, priority order:
  - latched port == 0: code 11, no table change.
  - bind and match: code 01.
  - bind and no free entry: code 10.
  - bind otherwise: write {1, port} to the first free entry, code 00.
  - release and match at index 0: code 01, entry stays.
  - release and match elsewhere: clear valid, code 00.
  - release and no match: code 11.
- RESP:
  - Drive rsp_valid=1 with rsp_id and rsp_code for one cycle.
  - Go to IDLE.
  - No backpressure: requesters must sample the response when rsp_valid is high.
- bound_count updates in the cycle after COMMIT and always equals the popcount of the valid bits.
- Requester-side rules:
  - A requester's req_valid and req_port must stay stable until its req_ready.
  - Changes to req_valid or req_port after its req_ready are ignored.
  - A requester may re-request only after its response.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_code=00, bound_count=1, state IDLE, rr_ptr=0.
- Per-request latency, with the accept cycle as T:
  - req_ready at T.
  - SCAN from T+1 to T+NENT.
  - COMMIT at T+NENT+1.
  - rsp_valid at T+NENT+2.
- The earliest next accept is T+NENT+3. Throughput is one request per NENT+3 cycles.
- req_ready is never asserted outside IDLE, and at most one bit is asserted per cycle.
- rst during SCAN, COMMIT or RESP:
  - The in-flight request is dropped and no response is issued.
  - The table returns to its reset contents.
  - The dropped requester must re-issue its request.
- A table write and the next-state change happen on the same clock edge at COMMIT. A following request's scan sees the updated table.
- Port comparison is a full PORTW-bit equality; no wildcard.

## Test plan
- Reset, then requester 1 binds 80 → accepted at T, rsp at T+10 (NENT=8) with id=1, code 00; bound_count 1→2.
- Requesters 0 and 2 both bind 8080 in the same cycle after reset → requester 0 is granted first and gets 00. Requester 2 is granted at T+11 and gets 01. rr_ptr then points to 3.
- Bind 22202 → 01; release 22202 → 01; bound_count stays 1.
- Bind 7 distinct ports 1001..1007, then bind 1008 → the first seven get 00 and bound_count=8. Port 1008 gets 10.
- Release 1003, then bind 1008 → release returns 00. The bind fills entry 3 and returns 00.
- Release unbound port 5555 → 11; bind port 0 → 11.
- Assert rst at T+4 of a bind to 80 → no rsp_valid; bound_count=1. A re-issued bind to 80 returns 00.
